// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
// Schedules the game-logic update so board state only changes inside vertical
// blanking. Divides frames into game ticks (speed+1 frames per tick), runs a
// req/done handshake with the game logic, and flags updates that are still
// pending when active video resumes.
// Optional feature: define SCHED_WATCHDOG_EN to add a request watchdog that
// abandons a request after WD_CYCLES clocks and raises the sticky wd_fault.
module vblank_update_scheduler #(
    parameter int VA_END    = 479,
    parameter int SCREEN    = 524,
    parameter int SPEED_W   = 4,
    parameter int CNT_W     = 8,
    parameter int WD_CYCLES = 32000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    input  logic               upd_done,
    output logic               upd_req,
    output logic               upd_start,
    output logic               frame_tick,
    output logic               in_vblank,
    output logic               overrun,
    output logic [CNT_W-1:0]   overrun_cnt,
    output logic               wd_fault
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

    // First blanking line; frame geometry without a blanking interval never starts one.
    localparam logic [9:0] VB_LINE = 10'(VA_END + 1);
    localparam bit         GEOM_OK = (VA_END < SCREEN);

    state_t             state;
    logic [SPEED_W-1:0] frame_cnt;
    logic               vb_start;
    logic               vb_end;
    logic               wd_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign vb_start = GEOM_OK && (pos_x == 10'd0) && (pos_y == VB_LINE);
    assign vb_end   = (pos_x == 10'd0) && (pos_y == 10'd0);

    // Vertical-blank flag and per-frame tick, both one cycle behind the position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_vblank  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= vb_start;
            if (vb_end)
                in_vblank <= 1'b0;
            else if (vb_start)
                in_vblank <= 1'b1;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int             WD_W    = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // A completion arriving on the last allowed cycle still wins over the fault.
    assign wd_hit = (state == S_REQ) && (wd_cnt == WD_LAST) && !upd_done;

    // Request age counter (zero on the first REQ cycle) and sticky fault flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt   <= '0;
            wd_fault <= 1'b0;
        end else begin
            if (state == S_REQ)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_hit)
                wd_fault <= 1'b1;
        end
    end
`else
    // Without the watchdog a request waits for its completion indefinitely.
    assign wd_hit   = 1'b0;
    assign wd_fault = (WD_CYCLES < 0);
`endif

    // Scheduler FSM: tick division, request handshake and overrun bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            frame_cnt   <= '0;
            upd_req     <= 1'b0;
            upd_start   <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            upd_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_WAIT;
                        frame_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (vb_start) begin
                        // >= so a speed decrease below the running count fires at once
                        if (frame_cnt >= speed) begin
                            state     <= S_REQ;
                            upd_req   <= 1'b1;
                            upd_start <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // Active video resumed with the update still pending.
                    if (vb_end) begin
                        overrun     <= 1'b1;
                        overrun_cnt <= sat_inc(overrun_cnt);
                    end
                    if (upd_done) begin
                        upd_req <= 1'b0;
                        state   <= enable ? S_WAIT : S_IDLE;
                    end else if (wd_hit) begin
                        upd_req   <= 1'b0;
                        state     <= S_WAIT;
                        frame_cnt <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    upd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Bench for vblank_update_scheduler. A compressed timing generator (16 pixels
// per line, a subset of lines including the whole 480..487 and 524 blanking
// lines used here) drives pos_x/pos_y; upd_start and frame_tick times are
// predicted into queues when (0,480) is driven and popped when the DUT pulses.
module tb_vblank_update_scheduler;

    localparam int H      = 16;
    localparam int NL     = 13;
    localparam int FRAME  = H * NL;
    localparam int VB_CYC = 9 * H;   // lines 480..487 and 524

    logic       clk;
    logic       reset_n;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       enable;
    logic [3:0] speed;
    logic       upd_done;
    logic       upd_req;
    logic       upd_start;
    logic       frame_tick;
    logic       in_vblank;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic       wd_fault;

    logic auto_done;
    logic man_done;
    assign upd_done = auto_done | man_done;

    vblank_update_scheduler #(
        .VA_END(479), .SCREEN(524), .SPEED_W(4), .CNT_W(8), .WD_CYCLES(100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pos_x(pos_x), .pos_y(pos_y),
        .enable(enable), .speed(speed), .upd_done(upd_done),
        .upd_req(upd_req), .upd_start(upd_start), .frame_tick(frame_tick),
        .in_vblank(in_vblank), .overrun(overrun), .overrun_cnt(overrun_cnt),
        .wd_fault(wd_fault)
    );

    typedef struct {
        int          speed;
        int          frames;
        int          dly;
        logic [31:0] mask;
        int          starts;
    } row_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vb_idx   = 0;
    logic [31:0] exp_mask = '0;
    bit  armed   = 0;
    bit  resp_en = 1;
    int  dly     = 5;
    bit  chk_w   = 0;
    int  exp_w   = 0;
    bit  chk_vb  = 0;
    int  n_start = 0;
    int  n_tick  = 0;
    int  st_q[$];
    int  ft_q[$];
    int  ly[NL] = '{0, 1, 2, 479, 480, 481, 482, 483, 484, 485, 486, 487, 524};
    row_t rows[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pos(input int x, input int y);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (pos_x == 10'(x) && pos_y == 10'(y)) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_pos(%0d,%0d): not reached within %0d cycles", x, y, 3 * FRAME);
    endtask

    task automatic wait_vb(input int n);
        for (int i = 0; i < (n + 2) * FRAME; i++) begin
            if (vb_idx >= n) return;
            @(negedge clk);
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_vb(%0d): only %0d vblank starts seen", n, vb_idx);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Timing generator; predicts tick/start times one cycle after (0,480).
    initial begin
        pos_x = '0;
        pos_y = '0;
        forever begin
            for (int li = 0; li < NL; li++) begin
                for (int x = 0; x < H; x++) begin
                    @(posedge clk);
                    #1;
                    pos_x = 10'(x);
                    pos_y = 10'(ly[li]);
                    if (x == 0 && ly[li] == 480 && reset_n) begin
                        ft_q.push_back(cyc + 1);
                        if (armed && vb_idx < 32 && exp_mask[vb_idx]) st_q.push_back(cyc + 1);
                        vb_idx++;
                    end
                end
            end
        end
    end

    // Game-logic responder: completes dly+1 cycles into each request.
    initial begin
        int age;
        age = 0;
        auto_done = 0;
        forever begin
            @(posedge clk);
            #1;
            if (upd_req && resp_en) begin
                age++;
                auto_done = (age == dly + 1);
            end else begin
                age = 0;
                auto_done = 0;
            end
        end
    end

    // Output monitor at the falling edge.
    initial begin
        int wr;
        int wv;
        wr = 0;
        wv = 0;
        forever begin
            @(negedge clk);
            if (upd_start) begin
                n_start++;
                check("upd_start_expected", 32'(st_q.size() > 0), 1);
                if (st_q.size() > 0) check("upd_start_cycle", cyc, st_q.pop_front());
            end
            if (frame_tick) begin
                n_tick++;
                check("frame_tick_expected", 32'(ft_q.size() > 0), 1);
                if (ft_q.size() > 0) check("frame_tick_cycle", cyc, ft_q.pop_front());
            end
            if (upd_req) wr++;
            else begin
                if (wr > 0 && chk_w) check("upd_req_width", wr, exp_w);
                wr = 0;
            end
            if (in_vblank) wv++;
            else begin
                if (wv > 0 && chk_vb) check("in_vblank_width", wv, VB_CYC);
                wv = 0;
            end
        end
    end

    initial begin
        rows[0] = '{speed: 0, frames: 3, dly: 5,  mask: 32'b111,      starts: 3};
        rows[1] = '{speed: 3, frames: 8, dly: 5,  mask: 32'b10001000, starts: 2};
        rows[2] = '{speed: 1, frames: 4, dly: 0,  mask: 32'b1010,     starts: 2};
        rows[3] = '{speed: 0, frames: 2, dly: 20, mask: 32'b11,       starts: 2};

        reset_n  = 0;
        enable   = 0;
        speed    = '0;
        man_done = 0;
        repeat (3) @(negedge clk);
        check("rst_upd_req", upd_req, 0);
        check("rst_upd_start", upd_start, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_in_vblank", in_vblank, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
        check("rst_wd_fault", wd_fault, 0);
        #2 reset_n = 1;

        // Table rows: tick division and handshake widths.
        foreach (rows[r]) begin
            wait_pos(0, 1);
            speed    = 4'(rows[r].speed);
            dly      = rows[r].dly;
            exp_w    = rows[r].dly + 1;
            exp_mask = rows[r].mask;
            vb_idx   = 0;
            n_start  = 0;
            n_tick   = 0;
            chk_w    = 1;
            chk_vb   = 1;
            armed    = 1;
            enable   = 1;
            wait_vb(rows[r].frames);
            wait_pos(0, 2);
            armed  = 0;
            chk_w  = 0;
            chk_vb = 0;
            check("row_upd_starts", n_start, rows[r].starts);
            check("row_frame_ticks", n_tick, rows[r].frames);
            check("row_overrun", overrun, 0);
            enable = 0;
        end

        // Overrun: completion withheld past the end of blanking.
        resp_en = 0;
        wait_pos(0, 1);
        speed    = '0;
        exp_mask = 32'b1;
        vb_idx   = 0;
        n_start  = 0;
        armed    = 1;
        enable   = 1;
        wait_vb(1);
        wait_pos(0, 0);
        check("ovr_before_vb_end", overrun, 0);
        check("ovr_req_held", upd_req, 1);
        @(negedge clk);
        check("ovr_flag", overrun, 1);
        check("ovr_cnt", overrun_cnt, 1);
        wait_vb(2);
        repeat (2) @(negedge clk);
        check("ovr_no_extra_start", n_start, 1);
        check("ovr_req_still_held", upd_req, 1);
        man_done = 1;
        enable   = 0;
        @(negedge clk);
        man_done = 0;
        check("ovr_req_released", upd_req, 0);
        check("ovr_sticky", overrun, 1);
        armed = 0;

        // Asynchronous reset in the middle of a request.
        wait_pos(0, 1);
        exp_mask = 32'b1;
        vb_idx   = 0;
        n_start  = 0;
        armed    = 1;
        enable   = 1;
        wait_vb(1);
        repeat (3) @(negedge clk);
        check("mid_req_before_reset", upd_req, 1);
        #2 reset_n = 0;
        #1;
        check("areset_upd_req", upd_req, 0);
        check("areset_in_vblank", in_vblank, 0);
        check("areset_overrun", overrun, 0);
        check("areset_overrun_cnt", overrun_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        vb_idx  = 0;
        n_start = 0;
        dly     = 2;
        resp_en = 1;
        #2 reset_n = 1;
        wait_vb(1);
        repeat (2) @(negedge clk);
        check("post_reset_first_req", n_start, 1);
        repeat (6) @(negedge clk);
        check("post_reset_req_done", upd_req, 0);
        enable = 0;
        armed  = 0;

        // Enable dropped mid-request: handshake completes, then idle.
        wait_pos(0, 1);
        dly      = 20;
        exp_w    = 21;
        exp_mask = 32'b1;
        vb_idx   = 0;
        n_start  = 0;
        n_tick   = 0;
        chk_w    = 1;
        armed    = 1;
        enable   = 1;
        wait_vb(1);
        @(negedge clk);
        enable = 0;
        check("en_drop_req_high", upd_req, 1);
        wait_vb(3);
        repeat (2) @(negedge clk);
        check("en_drop_starts", n_start, 1);
        check("en_drop_ticks", n_tick, 3);
        check("en_drop_req_low", upd_req, 0);
        chk_w = 0;
        armed = 0;

`ifdef SCHED_WATCHDOG_EN
        // Watchdog abandons an unanswered request after 100 cycles.
        resp_en = 0;
        wait_pos(0, 1);
        exp_w    = 100;
        exp_mask = 32'b11;
        vb_idx   = 0;
        n_start  = 0;
        chk_w    = 1;
        armed    = 1;
        enable   = 1;
        wait_vb(1);
        @(negedge clk);
        check("wd_fault_before", wd_fault, 0);
        for (int i = 0; i < 150 && upd_req; i++) @(negedge clk);
        check("wd_req_dropped", upd_req, 0);
        check("wd_fault_set", wd_fault, 1);
        wait_vb(2);
        repeat (2) @(negedge clk);
        check("wd_next_request", n_start, 2);
        enable = 0;
        repeat (110) @(negedge clk);
        chk_w = 0;
        armed = 0;
        check("wd_fault_end", wd_fault, 1);
`else
        check("wd_fault_tied_low", wd_fault, 0);
`endif

        check("start_queue_drained", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Sequences the game-logic update so board state changes only during vertical blanking, never mid-frame.
- Watches pos_x/pos_y from the 640x480 VGA timing generator and divides frames into game ticks.
- Runs a req/done handshake with the game-logic block and flags updates that spill into active video.
- Sits between the VGA timing generator and the snake game-state logic.

Parameters:
- VA_END, 479, last active line.
- SCREEN, 524, last line of frame.
- SPEED_W, 4, width of speed input.
- CNT_W, 8, width of overrun counter.
- WD_CYCLES, 32000, watchdog limit in clk cycles (used only with the macro).

Ports:
- clk  in  1  pixel clock, same domain as timing generator.
- reset_n  in  1  asynchronous active-low reset.
- pos_x  in  10  current pixel column from timing generator.
- pos_y  in  10  current line from timing generator.
- enable  in  1  scheduler run enable.
- speed  in  SPEED_W  frames per tick minus 1 (0 = every frame).
- upd_done  in  1  game logic finished update (1-cycle pulse or level).
- upd_req  out  1  update request, held until done accepted.
- upd_start  out  1  1-cycle pulse on first cycle of upd_req.
- frame_tick  out  1  1-cycle pulse per frame at vblank start.
- in_vblank  out  1  registered vertical-blank flag.
- overrun  out  1  sticky: an update was still pending when active video resumed.
- overrun_cnt  out  CNT_W  saturating count of overruns.
- wd_fault  out  1  sticky watchdog fault; tied 0 without macro.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - State IDLE; frame_cnt=0; wd counter=0.
  - Applies mid-handshake with no completion.
- Events (combinational, from inputs):
  - vb_start = (pos_x==0 && pos_y==VA_END+1).
  - vb_end = (pos_x==0 && pos_y==0).
  - All outputs are registered: each reacts the cycle after the event is presented.
- in_vblank: set on vb_start, cleared on vb_end. If both are true at once (impossible with legal params), clear wins.
- frame_tick: pulses on every vb_start, independent of state and enable.
- FSM:
  - IDLE: enable=1 -> WAIT, frame_cnt=0.
  - WAIT:
    - enable=0 -> IDLE.
    - On vb_start with frame_cnt==speed: go REQ, set upd_req=1, pulse upd_start, frame_cnt=0.
    - On vb_start otherwise: frame_cnt+1.
  - REQ:
    - upd_req held at 1. frame_cnt frozen.
    - On upd_done=1: upd_req=0 next cycle; go WAIT if enable, else IDLE.
    - vb_end seen while in REQ: overrun=1, overrun_cnt+1 (saturates at all-ones), stay in REQ.
    - Later vb_start events while in REQ are ignored for scheduling; the tick is dropped, not queued.
- upd_done is ignored outside REQ. upd_done in the first upd_req cycle is accepted, giving a 1-cycle request.
- Same cycle as vb_end and upd_done in REQ: completion is accepted and the overrun is still recorded.
- enable=0 in REQ: handshake completes normally, then IDLE.
- speed is sampled at each vb_start compare. Changes take effect at the next compare. frame_cnt > speed after a speed decrease counts as match.
- frame_cnt width is SPEED_W.
- overrun and overrun_cnt clear only on reset.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - Counter starts at 0 on REQ entry and increments each REQ cycle.
  - On reaching WD_CYCLES-1 without upd_done: drop upd_req, set wd_fault (sticky), go WAIT, frame_cnt=0.
  - upd_done in the same cycle wins; no fault.
- Undefined: no counter; wd_fault constant 0; REQ waits indefinitely.

Test Plan:
- Reset then enable=1, speed=0, free-running 800x525 timing, upd_done 5 cycles after upd_req -> one upd_start per frame, 1 cycle after pos=(0,480). upd_req high 6 cycles. overrun=0.
- speed=3 over 8 frames -> exactly 2 upd_start pulses (frames 4 and 8) and 8 frame_tick pulses. in_vblank high 45*800=36000 cycles per frame.
- upd_done withheld until after pos=(0,0) -> overrun=1 and overrun_cnt=1 the cycle after (0,0). upd_req stays 1 until upd_done; the vb_start during REQ produces no extra upd_start.
- reset_n pulsed low mid-REQ -> upd_req, overrun_cnt, in_vblank 0 immediately (async). With enable held at 1, the first request is at the next vb_start.
- enable dropped during REQ -> upd_req held until upd_done, then IDLE. No further upd_start while enable=0; frame_tick continues.
- SCHED_WATCHDOG_EN, WD_CYCLES=100, no upd_done -> upd_req falls after 100 cycles, wd_fault=1. The next request is issued at the following vb_start.
